// File: rtl/riscv_mini_pkg.sv
// riscv_mini_pkg: shared constants, instruction view and driver state encoding
// for the riscv_mini host-side driver.
package riscv_mini_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DATA_W  = 8;

  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_I = 2'b01;
  localparam logic [1:0] OP_L = 2'b10;
  localparam logic [1:0] OP_S = 2'b11;

  localparam logic [2:0] F3_OUT = 3'b000;
  localparam logic [2:0] F3_CMP = 3'b011;
  localparam logic [2:0] F3_SYS = 3'b111;

  // Load-class opcode with no register write: safe idle word for the core.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0002;

  // Field view of a 16-bit instruction as the driver decodes it.
  typedef struct packed {
    logic [2:0] f3;      // [15:13]
    logic       imm_hi;  // [12]   branch target bit 3
    logic       f2;      // [11]
    logic [5:0] mid;     // [10:5] core-only fields
    logic [2:0] imm_lo;  // [4:2]  branch target bits 2:0
    logic [1:0] op;      // [1:0]
  } instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/riscv_mini_if.sv
// riscv_mini_if: host load/control, core instruction/result and output FIFO
// signals of the riscv_mini driver. master = driver, slave = host/core side.
// With RISCV_MINI_STEP_LIMIT_EN defined an extra timeout flag is carried.
interface riscv_mini_if
  import riscv_mini_pkg::*;
#(
  parameter int unsigned PTR_W = 4
) ();

  logic               load_valid;
  logic [DATA_W-1:0]  load_byte;
  logic               load_ready;
  logic               clear;
  logic               start;
  logic               busy;
  logic               done;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  result;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_ready;
  logic [PTR_W-1:0]   pc;
`ifdef RISCV_MINI_STEP_LIMIT_EN
  logic               timeout;

  modport master (
    input  load_valid, load_byte, clear, start, result, out_ready,
    output load_ready, busy, done, instr, out_valid, out_data, pc, timeout
  );
  modport slave (
    output load_valid, load_byte, clear, start, result, out_ready,
    input  load_ready, busy, done, instr, out_valid, out_data, pc, timeout
  );
`else
  modport master (
    input  load_valid, load_byte, clear, start, result, out_ready,
    output load_ready, busy, done, instr, out_valid, out_data, pc
  );
  modport slave (
    output load_valid, load_byte, clear, start, result, out_ready,
    input  load_ready, busy, done, instr, out_valid, out_data, pc
  );
`endif

endinterface

// File: rtl/riscv_mini_out_fifo.sv
// riscv_mini_out_fifo: synchronous FIFO with full/empty flags.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data (head),
// full, empty. Push is dropped when full, pop is dropped when empty.
module riscv_mini_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/riscv_mini_driver.sv
// riscv_mini_driver: host-side initiator for the 16-bit instruction / 8-bit
// result core. Loads a program byte-serially, issues one instruction per RUN
// cycle, resolves output/branch/halt and queues output bytes for the host.
// Ports: clk, rst (sync, active-high), bus (riscv_mini_if.master): load
// channel, clear/start/busy/done, instr/result to the core, output FIFO, pc.
// Optional: RISCV_MINI_STEP_LIMIT_EN adds a 255-issue limit and bus.timeout.
module riscv_mini_driver
  import riscv_mini_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PTR_W     = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  riscv_mini_if.master bus
);

  localparam int unsigned LEN_W = PTR_W + 1;

  state_t             state_q, state_n;
  logic [PTR_W-1:0]   pc_q, pc_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic               half_q, half_n;
  logic [DATA_W-1:0]  lo_q, lo_n;
  logic               busy_q, done_q, load_ready_q;
  logic               mem_we;
  logic [INSTR_W-1:0] mem [DEPTH];
  instr_t             dec;
  logic               is_out, is_br, is_halt, stall, push;
  logic               fifo_full, fifo_empty;
  logic [DATA_W-1:0]  fifo_head;
  logic [LEN_W-1:0]   pc_inc, pc_tgt;
  logic               unused_mid;
`ifdef RISCV_MINI_STEP_LIMIT_EN
  logic [7:0]         cnt_q, cnt_n;
  logic               timeout_q, timeout_n;
`endif

  // Current word decode
  assign dec        = instr_t'(mem[pc_q]);
  assign unused_mid = ^dec.mid;
  assign is_out     = (dec.op == OP_S) && (dec.f3 == F3_OUT);
  assign is_br      = (dec.op == OP_S) && (dec.f3 == F3_CMP);
  assign is_halt    = (dec.op == OP_S) && (dec.f3 == F3_SYS) && dec.f2;
  // A full FIFO freezes the output instruction without side effects.
  assign stall      = is_out && fifo_full;
  assign pc_inc     = LEN_W'(pc_q) + LEN_W'(1);
  assign pc_tgt     = (is_br && bus.result[0])
                    ? LEN_W'(PTR_W'({dec.imm_hi, dec.imm_lo}))
                    : pc_inc;

  assign bus.instr      = (state_q == RUN) ? mem[pc_q] : NOP_INSTR;
  assign bus.pc         = pc_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_ready = load_ready_q;
  assign bus.out_valid  = !fifo_empty;
  assign bus.out_data   = fifo_head;
`ifdef RISCV_MINI_STEP_LIMIT_EN
  assign bus.timeout    = timeout_q;
`endif

  // Next-state and datapath control
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    len_n   = len_q;
    half_n  = half_q;
    lo_n    = lo_q;
    mem_we  = 1'b0;
    push    = 1'b0;
`ifdef RISCV_MINI_STEP_LIMIT_EN
    cnt_n     = cnt_q;
    timeout_n = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.clear) begin
          len_n  = '0;
          half_n = 1'b0;
        end else if (bus.start) begin
          half_n  = 1'b0;
          pc_n    = '0;
          state_n = (len_q == '0) ? DONE : RUN;
`ifdef RISCV_MINI_STEP_LIMIT_EN
          cnt_n     = '0;
          timeout_n = 1'b0;
`endif
        end else if (bus.load_valid && (len_q != LEN_W'(DEPTH))) begin
          half_n = !half_q;
          if (half_q) begin
            mem_we = 1'b1;
            len_n  = len_q + LEN_W'(1);
          end else begin
            lo_n = bus.load_byte;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          push = is_out;
          if (is_halt || (pc_tgt == len_q)) state_n = DONE;
          else                              pc_n    = pc_tgt[PTR_W-1:0];
`ifdef RISCV_MINI_STEP_LIMIT_EN
          cnt_n = cnt_q + 8'd1;
          if (cnt_q == 8'd254) begin
            state_n   = DONE;
            timeout_n = 1'b1;
          end
`endif
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      len_q        <= '0;
      half_q       <= 1'b0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef RISCV_MINI_STEP_LIMIT_EN
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_n;
      pc_q         <= pc_n;
      len_q        <= len_n;
      half_q       <= half_n;
      lo_q         <= lo_n;
      busy_q       <= (state_n == RUN);
      done_q       <= (state_n == DONE);
      load_ready_q <= (state_n == IDLE);
`ifdef RISCV_MINI_STEP_LIMIT_EN
      cnt_q        <= cnt_n;
      timeout_q    <= timeout_n;
`endif
    end
  end

  // Program memory (not reset)
  always_ff @(posedge clk) begin
    if (mem_we) mem[len_q[PTR_W-1:0]] <= {bus.load_byte, lo_q};
  end

  riscv_mini_out_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.result),
    .pop       (bus.out_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
